// File: rtl/sysid_pkg.sv
// Shared types and helpers for the system-ID checker.
// Build option: define SYSID_RECHECK_EN to add periodic automatic re-checks.
package sysid_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RD_ID,
        S_RD_TS,
        S_CMP
    } sysid_state_t;

    localparam logic ADDR_ID = 1'b0;
    localparam logic ADDR_TS = 1'b1;

    // Counter width able to hold max_count, never narrower than 8 bits.
    function automatic int timer_width(input int max_count);
        int w;
        w = $clog2(max_count + 1);
        return (w < 8) ? 8 : w;
    endfunction

endpackage

// File: rtl/sysid_wait_timer.sv
// Load/enable down-counter with terminal-count expire.
// expire is high on the enabled cycle that would take the count from 1 to 0,
// i.e. on the load_value-th enabled cycle after a load.
module sysid_wait_timer #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic             en,
    input  logic [WIDTH-1:0] load_value,
    output logic             expire
);

    logic [WIDTH-1:0] count;

    // Reload on reset or request, otherwise count down while enabled.
    always_ff @(posedge clock) begin
        if (reset || load) begin
            count <= load_value;
        end else if (en && (count != '0)) begin
            count <= count - WIDTH'(1);
        end
    end

    assign expire = en && (count == WIDTH'(1));

endmodule

// File: rtl/sysid_checker.sv
// Avalon-MM read master that fetches the sysid ID and timestamp words and
// compares them with the values the image was built against.
// Build option: SYSID_RECHECK_EN adds a periodic re-check every RECHECK_PERIOD cycles.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | waiting for start, auto-start or a pending periodic request
// S_RD_ID | reading address 0 (ID word), stall-guarded
// S_RD_TS | reading address 1 (timestamp word), stall-guarded
// S_CMP   | compare captured words, pulse done
module sysid_checker
    import sysid_pkg::*;
#(
    parameter logic [31:0] EXPECTED_ID    = 32'h0000_0000,
    parameter logic [31:0] EXPECTED_TS    = 32'd1417464043,
    parameter int          TIMEOUT_CYCLES = 255,
    parameter int          RECHECK_PERIOD = 1000000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    output logic        avm_address,
    output logic        avm_read,
    input  logic [31:0] avm_readdata,
    input  logic        avm_waitrequest,
    output logic        busy,
    output logic        done,
    output logic        id_match,
    output logic        ts_match,
    output logic        timeout,
    output logic [31:0] id_value,
    output logic [31:0] ts_value
);

    localparam int WAIT_W = timer_width(TIMEOUT_CYCLES);

    if ((TIMEOUT_CYCLES < 1) || (RECHECK_PERIOD < 2)) begin : g_bad_cfg
        $error("sysid_checker: TIMEOUT_CYCLES must be >= 1 and RECHECK_PERIOD >= 2");
    end

    sysid_state_t state;
    logic         pending;
    logic         launch;
    logic         stall;
    logic         wait_expire;
    logic         recheck_req;

    assign launch = (state == S_IDLE) && (start || pending);
    assign stall  = ((state == S_RD_ID) || (state == S_RD_TS)) && avm_read && avm_waitrequest;

    // Counts consecutive stalled cycles of the current read; any non-stalled
    // cycle (accepted read or idle) reloads it.
    sysid_wait_timer #(
        .WIDTH (WAIT_W)
    ) u_wait_timer (
        .clock      (clock),
        .reset      (reset),
        .load       (!stall),
        .en         (stall),
        .load_value (WAIT_W'(TIMEOUT_CYCLES)),
        .expire     (wait_expire)
    );

`ifdef SYSID_RECHECK_EN
    localparam int PER_W = timer_width(RECHECK_PERIOD);

    logic period_expire;

    // Free-running period counter, reloads itself on every expiry.
    sysid_wait_timer #(
        .WIDTH (PER_W)
    ) u_period_timer (
        .clock      (clock),
        .reset      (reset),
        .load       (period_expire),
        .en         (1'b1),
        .load_value (PER_W'(RECHECK_PERIOD)),
        .expire     (period_expire)
    );

    assign recheck_req = period_expire;
`else
    assign recheck_req = 1'b0;
`endif

    // Check sequencer with registered bus strobes and results.
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= S_IDLE;
            pending     <= 1'b1;
            avm_address <= ADDR_ID;
            avm_read    <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            id_match    <= 1'b0;
            ts_match    <= 1'b0;
            timeout     <= 1'b0;
            id_value    <= '0;
            ts_value    <= '0;
        end else begin
            done <= 1'b0;

            // A launch consumes any request; a request arriving while busy waits.
            if (launch) begin
                pending <= 1'b0;
            end else if (recheck_req) begin
                pending <= 1'b1;
            end

            case (state)
                S_IDLE: begin
                    if (launch) begin
                        timeout     <= 1'b0;
                        avm_address <= ADDR_ID;
                        avm_read    <= 1'b1;
                        busy        <= 1'b1;
                        state       <= S_RD_ID;
                    end
                end
                S_RD_ID: begin
                    if (!avm_waitrequest) begin
                        id_value    <= avm_readdata;
                        avm_address <= ADDR_TS;
                        state       <= S_RD_TS;
                    end else if (wait_expire) begin
                        avm_read <= 1'b0;
                        timeout  <= 1'b1;
                        id_match <= 1'b0;
                        ts_match <= 1'b0;
                        done     <= 1'b1;
                        busy     <= 1'b0;
                        state    <= S_IDLE;
                    end
                end
                S_RD_TS: begin
                    if (!avm_waitrequest) begin
                        ts_value <= avm_readdata;
                        avm_read <= 1'b0;
                        state    <= S_CMP;
                    end else if (wait_expire) begin
                        avm_read <= 1'b0;
                        timeout  <= 1'b1;
                        id_match <= 1'b0;
                        ts_match <= 1'b0;
                        done     <= 1'b1;
                        busy     <= 1'b0;
                        state    <= S_IDLE;
                    end
                end
                S_CMP: begin
                    id_match <= (id_value == EXPECTED_ID);
                    ts_match <= (ts_value == EXPECTED_TS);
                    done     <= 1'b1;
                    busy     <= 1'b0;
                    state    <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
